// File: rtl/comet_mmio_port.sv
// comet_mmio_port: COMET II memory-mapped I/O responder.
// Four-word window at BASE_ADDR:
//   +0 TXDATA (write pushes the TX FIFO)
//   +1 STATUS
//   +2 RXDATA (read pops the RX FIFO)
//   +3 CTRL
// TX FIFO feeds an external stream sink. RX FIFO collects externally strobed words.
// Optional feature macro: COMET_MMIO_RX_EN enables the RX FIFO, RXDATA, rx_overflow
// and rx_irq_en. When it is undefined, the RX side reads as zero.
module comet_mmio_port #(
  parameter logic [15:0] BASE_ADDR     = 16'hFF00,
  parameter int          TX_DEPTH_LOG2 = 3,
  parameter int          RX_DEPTH_LOG2 = 3
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic        re,
  input  logic [15:0] raddr,
  output logic [15:0] rdata,
  output logic        rhit,
  input  logic        we,
  input  logic [15:0] waddr,
  input  logic [15:0] wdata,
  output logic        tx_valid,
  output logic [15:0] tx_data,
  input  logic        tx_ready,
  input  logic        rx_strobe,
  input  logic [15:0] rx_data,
  output logic        irq
);

  typedef enum logic [1:0] {
    OFF_TXDATA = 2'd0,
    OFF_STATUS = 2'd1,
    OFF_RXDATA = 2'd2,
    OFF_CTRL   = 2'd3
  } reg_off_e;

  localparam int                     TX_DEPTH    = 1 << TX_DEPTH_LOG2;
  localparam logic [TX_DEPTH_LOG2:0] TX_FULL_CNT = (TX_DEPTH_LOG2+1)'(TX_DEPTH);
  localparam logic [TX_DEPTH_LOG2:0] TX_CNT_ONE  = (TX_DEPTH_LOG2+1)'(1);
  localparam logic [TX_DEPTH_LOG2-1:0] TX_PTR_ONE = TX_DEPTH_LOG2'(1);

  // Bus decode
  logic     rd_hit, wr_hit;
  reg_off_e rd_off, wr_off;
  assign rd_hit = re & (raddr[15:2] == BASE_ADDR[15:2]);
  assign wr_hit = we & (waddr[15:2] == BASE_ADDR[15:2]);
  assign rd_off = reg_off_e'(raddr[1:0]);
  assign wr_off = reg_off_e'(waddr[1:0]);

  logic ctrl_wr, sticky_clr, tx_flush;
  assign ctrl_wr    = wr_hit & (wr_off == OFF_CTRL);
  assign sticky_clr = ctrl_wr & wdata[0];
  assign tx_flush   = ctrl_wr & wdata[1];

  // TX FIFO
  logic [15:0]              tx_mem [TX_DEPTH];
  logic [TX_DEPTH_LOG2-1:0] tx_wp, tx_rp;
  logic [TX_DEPTH_LOG2:0]   tx_cnt;
  logic tx_full, tx_empty, tx_push_req, tx_push, tx_pop, tx_drop_set;

  assign tx_full     = (tx_cnt == TX_FULL_CNT);
  assign tx_empty    = (tx_cnt == '0);
  assign tx_push_req = wr_hit & (wr_off == OFF_TXDATA);
  // A flush discards a same-cycle push silently; otherwise a push into a full FIFO is a drop.
  assign tx_push     = tx_push_req & ~tx_full & ~tx_flush;
  assign tx_drop_set = tx_push_req & tx_full & ~tx_flush;
  assign tx_pop      = ~tx_empty & tx_ready;

  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_empty ? 16'h0000 : tx_mem[tx_rp];

  // TX pointers and occupancy; a flush has priority over a push or a pop.
  always_ff @(posedge mclk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else if (tx_flush) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + TX_PTR_ONE;
      if (tx_pop)  tx_rp <= tx_rp + TX_PTR_ONE;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + TX_CNT_ONE;
        2'b01:   tx_cnt <= tx_cnt - TX_CNT_ONE;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  // TX storage write.
  always_ff @(posedge mclk) begin
    // NOTE: FIFO storage is not reset; the reset pointers and count make stale words unreachable.
    if (tx_push) tx_mem[tx_wp] <= wdata;
  end

  // RX side
  logic        rx_nonempty, rx_overflow, rx_irq_en;
  logic [15:0] rx_head;

`ifdef COMET_MMIO_RX_EN
  localparam int                     RX_DEPTH    = 1 << RX_DEPTH_LOG2;
  localparam logic [RX_DEPTH_LOG2:0] RX_FULL_CNT = (RX_DEPTH_LOG2+1)'(RX_DEPTH);
  localparam logic [RX_DEPTH_LOG2:0] RX_CNT_ONE  = (RX_DEPTH_LOG2+1)'(1);
  localparam logic [RX_DEPTH_LOG2-1:0] RX_PTR_ONE = RX_DEPTH_LOG2'(1);

  logic [15:0]              rx_mem [RX_DEPTH];
  logic [RX_DEPTH_LOG2-1:0] rx_wp, rx_rp;
  logic [RX_DEPTH_LOG2:0]   rx_cnt;
  logic rx_full, rx_push, rx_pop, rx_ovf_set;

  assign rx_full     = (rx_cnt == RX_FULL_CNT);
  assign rx_nonempty = (rx_cnt != '0);
  assign rx_push     = rx_strobe & ~rx_full;
  assign rx_ovf_set  = rx_strobe & rx_full;
  assign rx_pop      = rd_hit & (rd_off == OFF_RXDATA) & rx_nonempty;
  assign rx_head     = rx_nonempty ? rx_mem[rx_rp] : 16'h0000;

  // RX pointers and occupancy.
  always_ff @(posedge mclk) begin
    if (rst) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + RX_PTR_ONE;
      if (rx_pop)  rx_rp <= rx_rp + RX_PTR_ONE;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + RX_CNT_ONE;
        2'b01:   rx_cnt <= rx_cnt - RX_CNT_ONE;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // RX storage write.
  always_ff @(posedge mclk) begin
    if (rx_push) rx_mem[rx_wp] <= rx_data;
  end

  // RX sticky overflow (set beats clear) and RX interrupt enable.
  always_ff @(posedge mclk) begin
    if (rst) begin
      rx_overflow <= 1'b0;
      rx_irq_en   <= 1'b0;
    end else begin
      rx_overflow <= rx_ovf_set | (rx_overflow & ~sticky_clr);
      if (ctrl_wr) rx_irq_en <= wdata[2];
    end
  end
`else
  assign rx_nonempty = 1'b0;
  assign rx_overflow = 1'b0;
  assign rx_irq_en   = 1'b0;
  assign rx_head     = 16'h0000;

  logic rx_unused;
  assign rx_unused = ^{rx_strobe, rx_data, RX_DEPTH_LOG2[0]};
`endif

  // TX sticky drop (set beats clear) and TX interrupt enable.
  logic tx_drop, tx_irq_en;
  always_ff @(posedge mclk) begin
    if (rst) begin
      tx_drop   <= 1'b0;
      tx_irq_en <= 1'b0;
    end else begin
      tx_drop <= tx_drop_set | (tx_drop & ~sticky_clr);
      if (ctrl_wr) tx_irq_en <= wdata[3];
    end
  end

  logic wdata_unused;
  assign wdata_unused = ^wdata[15:4];

  assign irq = (rx_irq_en & rx_nonempty) | (tx_irq_en & tx_empty);

  // Read-data mux from pre-edge state.
  logic [15:0] rd_data_n;
  always_comb begin
    // NOTE: default first so every path assigns rd_data_n and no latch is inferred.
    rd_data_n = 16'h0000;
    if (rd_hit) begin
      case (rd_off)
        OFF_STATUS: rd_data_n = {8'(tx_cnt), 3'b000, tx_drop, rx_overflow,
                                 rx_nonempty, tx_empty, tx_full};
        OFF_RXDATA: rd_data_n = rx_head;
        OFF_CTRL:   rd_data_n = {12'h000, tx_irq_en, rx_irq_en, 2'b00};
        default:    rd_data_n = 16'h0000;
      endcase
    end
  end

  // Registered read response, one cycle after the sampled read.
  always_ff @(posedge mclk) begin
    if (rst) begin
      rdata <= 16'h0000;
      rhit  <= 1'b0;
    end else begin
      rdata <= rd_data_n;
      rhit  <= rd_hit;
    end
  end

endmodule

// File: tb/tb_comet_mmio_port.sv
// tb_comet_mmio_port: directed scenarios plus randomized traffic, checked every cycle
// against a queue-based model of the MMIO port. Follows COMET_MMIO_RX_EN like the DUT.
module tb_comet_mmio_port;

  localparam logic [15:0] BASE = 16'hFF00;
  localparam int TXD = 8;
  localparam int RXD = 8;
`ifdef COMET_MMIO_RX_EN
  localparam bit RX_ON = 1'b1;
`else
  localparam bit RX_ON = 1'b0;
`endif

  logic        mclk, rst, re, we, tx_ready, rx_strobe;
  logic [15:0] raddr, waddr, wdata, rx_data;
  logic [15:0] rdata, tx_data;
  logic        rhit, tx_valid, irq;

  comet_mmio_port #(.BASE_ADDR(BASE), .TX_DEPTH_LOG2(3), .RX_DEPTH_LOG2(3)) dut (
    .mclk(mclk), .rst(rst), .re(re), .raddr(raddr), .rdata(rdata), .rhit(rhit),
    .we(we), .waddr(waddr), .wdata(wdata), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_strobe(rx_strobe), .rx_data(rx_data), .irq(irq)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: FIFOs as queues, registers as plain bits.
  logic [15:0] tx_q[$];
  logic [15:0] rx_q[$];
  bit          m_drop, m_ovf, m_txen, m_rxen, m_rhit, model_live;
  logic [15:0] m_rdata;

  function automatic logic [15:0] status_word();
    return {8'(tx_q.size()), 3'b000, m_drop, m_ovf, rx_q.size() != 0,
            tx_q.size() == 0, tx_q.size() == TXD};
  endfunction

  task automatic model_step();
    int          txn, rxn;
    bit          hit_r, hit_w, ctrlw, flush, clr, push_req, drop_set, ovf_set, rx_pop;
    logic [15:0] rd;
    if (rst) begin
      tx_q.delete();
      rx_q.delete();
      m_drop = 0; m_ovf = 0; m_txen = 0; m_rxen = 0;
      m_rdata = 16'h0000; m_rhit = 0;
      model_live = 1;
      return;
    end
    txn    = tx_q.size();
    rxn    = rx_q.size();
    hit_r  = re && (raddr[15:2] == BASE[15:2]);
    rd     = 16'h0000;
    rx_pop = 0;
    if (hit_r) begin
      case (raddr[1:0])
        2'd1: rd = status_word();
        2'd2: if (RX_ON && rxn > 0) begin rd = rx_q[0]; rx_pop = 1; end
        2'd3: rd = {12'h000, m_txen, m_rxen, 2'b00};
        default: rd = 16'h0000;
      endcase
    end
    hit_w    = we && (waddr[15:2] == BASE[15:2]);
    ctrlw    = hit_w && (waddr[1:0] == 2'd3);
    flush    = ctrlw && wdata[1];
    clr      = ctrlw && wdata[0];
    push_req = hit_w && (waddr[1:0] == 2'd0);
    drop_set = push_req && (txn == TXD) && !flush;
    if (flush) tx_q.delete();
    else begin
      if (txn > 0 && tx_ready) void'(tx_q.pop_front());
      if (push_req && txn < TXD) tx_q.push_back(wdata);
    end
    ovf_set = 0;
    if (RX_ON) begin
      if (rx_pop) void'(rx_q.pop_front());
      if (rx_strobe) begin
        if (rxn < RXD) rx_q.push_back(rx_data);
        else ovf_set = 1;
      end
    end
    m_drop = drop_set || (m_drop && !clr);
    m_ovf  = ovf_set || (m_ovf && !clr);
    if (ctrlw) begin
      m_txen = wdata[3];
      m_rxen = RX_ON && wdata[2];
    end
    m_rdata = rd;
    m_rhit  = hit_r;
  endtask

  initial begin
    model_live = 0;
    forever begin
      @(posedge mclk);
      model_step();
    end
  end

  // Compare process: every cycle, away from the rising edge.
  initial begin
    forever begin
      @(negedge mclk);
      if (model_live) begin
        check("cmp_rdata", rdata, m_rdata);
        check("cmp_rhit", {15'b0, rhit}, {15'b0, m_rhit});
        check("cmp_tx_valid", {15'b0, tx_valid}, {15'b0, tx_q.size() != 0});
        check("cmp_tx_data", tx_data, (tx_q.size() != 0) ? tx_q[0] : 16'h0000);
        check("cmp_irq", {15'b0, irq},
              {15'b0, (m_rxen && rx_q.size() != 0) || (m_txen && tx_q.size() == 0)});
      end
    end
  end

  task automatic cyc();
    @(posedge mclk);
    #1;
  endtask

  task automatic idle();
    re = 0; we = 0; rx_strobe = 0;
    raddr = 16'h0000; waddr = 16'h0000; wdata = 16'h0000; rx_data = 16'h0000;
  endtask

  task automatic rd(input logic [15:0] a);
    re = 1; raddr = a;
    cyc();
    re = 0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    we = 1; waddr = a; wdata = d;
    cyc();
    we = 0;
  endtask

  task automatic strobe(input logic [15:0] d);
    rx_strobe = 1; rx_data = d;
    cyc();
    rx_strobe = 0;
  endtask

  initial begin
    rst = 1; tx_ready = 0;
    idle();
    repeat (2) cyc();
    rst = 0;
    check("reset_rdata", rdata, 16'h0000);
    check("reset_rhit", {15'b0, rhit}, 16'd0);
    check("reset_tx_valid", {15'b0, tx_valid}, 16'd0);
    check("reset_tx_data", tx_data, 16'h0000);
    check("reset_irq", {15'b0, irq}, 16'd0);

    rd(16'hFF01);
    check("status_after_reset", rdata, 16'h0002);
    check("status_rhit", {15'b0, rhit}, 16'd1);
    rd(16'h0123);
    check("miss_rdata", rdata, 16'h0000);
    check("miss_rhit", {15'b0, rhit}, 16'd0);

    // Fill TX, overflow it, then drain in order.
    for (int i = 0; i < 8; i++) wr(16'hFF00, 16'(16'h0041 + i));
    wr(16'hFF00, 16'h0049);
    rd(16'hFF01);
    check("status_tx_full_drop", rdata, 16'h0811);
    tx_ready = 1;
    for (int i = 0; i < 8; i++) begin
      check("tx_order", tx_data, 16'(16'h0041 + i));
      check("tx_valid_drain", {15'b0, tx_valid}, 16'd1);
      cyc();
    end
    check("tx_valid_empty", {15'b0, tx_valid}, 16'd0);
    rd(16'hFF01);
    check("status_tx_empty_drop", rdata, 16'h0012);
    wr(16'hFF03, 16'h0001);
    rd(16'hFF01);
    check("status_drop_cleared", rdata, 16'h0002);

    // Push into empty with sink ready: no bypass.
    wr(16'hFF00, 16'h0077);
    check("no_bypass_valid", {15'b0, tx_valid}, 16'd1);
    check("no_bypass_data", tx_data, 16'h0077);
    cyc();
    check("no_bypass_gone", {15'b0, tx_valid}, 16'd0);

    // Write on full while sink pops the same cycle: still dropped.
    tx_ready = 0;
    for (int i = 0; i < 8; i++) wr(16'hFF00, 16'(16'h0100 + i));
    tx_ready = 1;
    wr(16'hFF00, 16'h01FF);
    rd(16'hFF01);
    check("status_full_pop_drop", rdata, 16'h0710);
    repeat (8) cyc();
    wr(16'hFF03, 16'h0001);

`ifdef COMET_MMIO_RX_EN
    strobe(16'hBEEF);
    strobe(16'hCAFE);
    rd(16'hFF02); check("rx_pop_1", rdata, 16'hBEEF);
    rd(16'hFF02); check("rx_pop_2", rdata, 16'hCAFE);
    rd(16'hFF02); check("rx_pop_empty", rdata, 16'h0000);
    rd(16'hFF01); check("status_rx_empty", rdata, 16'h0002);
    for (int i = 0; i < 9; i++) strobe(16'(i + 1));
    rd(16'hFF01); check("status_rx_ovf", rdata, 16'h000E);
    wr(16'hFF03, 16'h0001);
    rd(16'hFF01); check("status_ovf_cleared", rdata, 16'h0006);
    rx_strobe = 1; rx_data = 16'h0AAA; we = 1; waddr = 16'hFF03; wdata = 16'h0001;
    cyc();
    idle();
    rd(16'hFF01); check("status_set_beats_clear", rdata, 16'h000E);
    repeat (8) rd(16'hFF02);
    wr(16'hFF03, 16'h0001);
    rd(16'hFF01); check("status_rx_drained", rdata, 16'h0002);

    wr(16'hFF03, 16'h000C);
    check("irq_tx_empty", {15'b0, irq}, 16'd1);
    tx_ready = 0;
    rx_strobe = 1; rx_data = 16'h1234; we = 1; waddr = 16'hFF00; wdata = 16'h0055;
    cyc();
    idle();
    check("irq_rx_nonempty", {15'b0, irq}, 16'd1);
    rd(16'hFF02);
    check("irq_rx_word", rdata, 16'h1234);
    check("irq_after_pop", {15'b0, irq}, 16'd0);
`else
    strobe(16'hBEEF);
    rd(16'hFF02); check("rxdata_disabled", rdata, 16'h0000);
    rd(16'hFF01); check("status_rx_disabled", rdata, 16'h0002);
    wr(16'hFF03, 16'h000C);
    rd(16'hFF03); check("ctrl_rx_en_zero", rdata, 16'h0008);
    check("irq_tx_empty", {15'b0, irq}, 16'd1);
    tx_ready = 0;
    wr(16'hFF00, 16'h0055);
    check("irq_tx_nonempty", {15'b0, irq}, 16'd0);
`endif
    tx_ready = 1;
    cyc();
    check("irq_tx_drained", {15'b0, irq}, 16'd1);
    wr(16'hFF03, 16'h0000);
    check("irq_disabled", {15'b0, irq}, 16'd0);

    // Reset in the middle of a drain.
    tx_ready = 0;
    for (int i = 0; i < 3; i++) wr(16'hFF00, 16'(16'h0200 + i));
    tx_ready = 1;
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    check("midreset_tx_valid", {15'b0, tx_valid}, 16'd0);
    check("midreset_tx_data", tx_data, 16'h0000);
    check("midreset_irq", {15'b0, irq}, 16'd0);
    rd(16'hFF01);
    check("midreset_status", rdata, 16'h0002);

    // Randomized traffic; the compare process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 299) == 0);
      re        = $urandom_range(0, 1) != 0;
      raddr     = ($urandom_range(0, 7) == 0) ? 16'($urandom) : (BASE | 16'($urandom_range(0, 3)));
      we        = $urandom_range(0, 1) != 0;
      waddr     = ($urandom_range(0, 7) == 0) ? 16'($urandom) : (BASE | 16'($urandom_range(0, 3)));
      wdata     = 16'($urandom);
      if (waddr[1:0] == 2'd3 && $urandom_range(0, 3) != 0) wdata[1] = 1'b0;
      tx_ready  = (n < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rx_strobe = $urandom_range(0, 1) != 0;
      rx_data   = 16'($urandom);
      cyc();
    end
    idle();
    rst = 0;
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/comet_mmio_port.md
# comet_mmio_port

Memory-mapped I/O responder on the COMET II CPU data bus (re/raddr/rdata, we/waddr/wdata). It answers the CPU's loads and stores in a 4-word window, buffers CPU stores into a TX FIFO drained by an external stream sink, and buffers external input words into an RX FIFO that the CPU pops by reading. It sits beside the program RAM at top level; the top ORs its `rdata` with the RAM's, gated by `rhit`.

## Interface
- BASE_ADDR, 16'hFF00, window base; bits [1:0] must be 0.
- TX_DEPTH_LOG2, 3, TX FIFO depth = 2**TX_DEPTH_LOG2 (1..7).
- RX_DEPTH_LOG2, 3, RX FIFO depth = 2**RX_DEPTH_LOG2 (1..7).
- mclk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- re  in  1  CPU read enable.
- raddr  in  16  CPU read address.
- rdata  out  16  read data, registered; 0 when no hit.
- rhit  out  1  registered; 1 in the cycle `rdata` carries window data.
- we  in  1  CPU write enable.
- waddr  in  16  CPU write address.
- wdata  in  16  CPU write data.
- tx_valid  out  1  TX FIFO not empty.
- tx_data  out  16  TX FIFO head (first-word fall-through); 0 when tx_valid=0.
- tx_ready  in  1  sink accepts head when tx_valid & tx_ready.
- rx_strobe  in  1  external word present this cycle (no backpressure).
- rx_data  in  16  external word.
- irq  out  1  level interrupt request.

## Operation
- Hit: address[15:2] == BASE_ADDR[15:2]; offset = address[1:0].
- Offset 0 TXDATA: write pushes wdata; read returns 0.
- Offset 1 STATUS (read-only): bit0 tx_full, bit1 tx_empty, bit2 rx_nonempty, bit3 rx_overflow (sticky), bit4 tx_drop (sticky), bits[15:8] TX occupancy count; others 0.
- Offset 2 RXDATA: read returns RX head and pops it; empty -> returns 0, no state change.
- Offset 3 CTRL: write bit0=1 clears both sticky bits; bit1=1 flushes TX FIFO; bit2 rx_irq_en, bit3 tx_irq_en stored. Read returns {12'b0, bit3, bit2, 2'b00}.
- Full/empty decisions use pre-edge state. TXDATA write when full: word dropped, tx_drop set, even if sink pops same cycle. Push to empty with tx_ready high: head not visible until next cycle (no bypass).
- rx_strobe when RX full: word dropped, rx_overflow set, even if CPU pops same cycle.
- Same-cycle sticky set and CTRL clear: set wins.
- Same-cycle CTRL flush and TXDATA push: flush wins, pushed word discarded, tx_drop not set.
- irq = (rx_irq_en & rx_nonempty) | (tx_irq_en & tx_empty), from registered state.
- Pointers are LOG2-bit wrapping; counts are LOG2+1 bits; full = count == depth.

## Timing
- Read latency 1: re sampled at edge N -> rdata/rhit valid after edge N until edge N+1; re=0 or miss -> rdata=0, rhit=0 next cycle.
- STATUS read returns values from before edge N; RXDATA pop takes effect at edge N.
- Writes take effect at sampling edge; STATUS read in the next cycle sees them.
- Reads and writes in the same cycle are independent.
- Reset: rdata=0, rhit=0, tx_valid=0, tx_data=0, irq=0; FIFOs empty, sticky bits 0, irq enables 0. Reset mid-transfer discards all buffered words; inputs ignored while rst=1.

## Configuration
- COMET_MMIO_RX_EN defined: RX FIFO, RXDATA, rx_overflow, rx_irq_en implemented as above.
- Not defined: no RX storage; rx_strobe/rx_data ignored; RXDATA reads 0; STATUS bits 2/3 read 0; CTRL bit2 stored as 0; irq = tx_irq_en & tx_empty.

## Test plan
- Reset, read STATUS (FF01) -> rdata=16'h0002 one cycle later, rhit=1; read 16'h0123 -> rdata=0, rhit=0.
- tx_ready=0, write 8'h41..8'h48 to FF00, then 16'h0049 -> STATUS=16'h0811 (count 8, full, drop); raise tx_ready -> tx_data 8'h41..8'h48 in order, then tx_valid=0, STATUS=16'h0012.
- With COMET_MMIO_RX_EN: strobe 16'hBEEF, 16'hCAFE; read FF02 twice -> BEEF then CAFE; third read -> 0, STATUS bit2=0.
- Strobe 9 words into RX -> bit3 set; write FF03=1 -> bit3 clear; same-cycle strobe-on-full and clear -> bit3 remains 1.
- Write FF03=16'h000C with RX empty, TX empty -> irq=1; strobe word, write TX word with tx_ready=0 -> irq stays 1 (RX); pop RX -> irq=0.
- Fill TX 3 words, assert rst one cycle mid-drain -> next cycle tx_valid=0, STATUS=16'h0002, irq=0.
